instr_fetch_ctrl: RTL and testbench

Instruction fetch controller that sits directly upstream of the 16-bit program-counter register. It drives that register's inc and write_en inputs and consumes its dataout as the fetch address. Each fetch reads one instruction word from instruction memory through a ready-based handshake. The word is held in an instruction buffer and offered to the decoder with a valid/ready handshake. Jumps are applied by loading the PC.

---
 rtl/instr_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the PC register (inc / load), issues
// one ready-handshaked instruction-memory read per word, buffers the word and
// offers it to the decoder with valid/ready. jump_req redirects the PC and
// takes priority over every other activity.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_inc,
  output logic               pc_write_en,
  output logic [ADDR_W-1:0]  pc_load,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               jump_req,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    JUMP
  } state_t;

  state_t state;

  // Fetch address is the live PC; only meaningful while mem_rd is high.
  assign mem_addr = pc_value;

  // Fetch FSM with registered outputs. pc_inc / pc_write_en default low so
  // each is a single-cycle strobe. A jump never sets pc_inc, and a jump seen
  // during the pc_inc cycle raises pc_write_en on the following cycle, so the
  // two strobes cannot coincide and the jump target wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_inc      <= 1'b0;
      pc_write_en <= 1'b0;
      pc_load     <= '0;
      mem_rd      <= 1'b0;
      ir_valid    <= 1'b0;
      ir_data     <= '0;
      ir_pc       <= '0;
    end else begin
      pc_inc      <= 1'b0;
      pc_write_en <= 1'b0;
      if (jump_req) begin
        pc_write_en <= 1'b1;
        pc_load     <= jump_addr;
        ir_valid    <= 1'b0;
        mem_rd      <= 1'b0;
        state       <= JUMP;
      end else begin
        case (state)
          IDLE: begin
            if (!halt) begin
              mem_rd <= 1'b1;
              state  <= REQ;
            end
          end
          REQ: begin
            if (mem_ready) begin
              ir_data  <= mem_rdata;
              ir_pc    <= pc_value;
              ir_valid <= 1'b1;
              pc_inc   <= 1'b1;
              mem_rd   <= 1'b0;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (ir_valid && ir_ready) begin
              ir_valid <= 1'b0;
              if (halt) begin
                state <= IDLE;
              end else begin
                mem_rd <= 1'b1;
                state  <= REQ;
              end
            end
          end
          JUMP: begin
            if (halt) begin
              state <= IDLE;
            end else begin
              mem_rd <= 1'b1;
              state  <= REQ;
            end
          end
          default: begin
            mem_rd <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  // The PC register treats inc and write_en together as hold; never drive both.
  pc_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(pc_inc && pc_write_en));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural PC register model.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_value;
  logic        pc_inc;
  logic        pc_write_en;
  logic [15:0] pc_load;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        jump_req;
  logic [15:0] jump_addr;
  logic        halt;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  int checks = 0;
  int errors = 0;

  int inc_count  = 0;
  int rd_count   = 0;
  int both_count = 0;
  int beef_count = 0;

  instr_fetch_ctrl #(.ADDR_W(16), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_value    (pc_value),
    .pc_inc      (pc_inc),
    .pc_write_en (pc_write_en),
    .pc_load     (pc_load),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .jump_req    (jump_req),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: load wins alone, inc alone increments, both = hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_value <= 16'h0000;
    else if (pc_write_en && !pc_inc) pc_value <= pc_load;
    else if (pc_inc && !pc_write_en) pc_value <= pc_value + 16'h0001;
  end

  // Event counters observed on every rising edge.
  always @(posedge clk) begin
    if (pc_inc) inc_count++;
    if (mem_rd) rd_count++;
    if (pc_inc && pc_write_en) both_count++;
    if (ir_valid && ir_data == 16'hBEEF) beef_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int inc0;
  int rd0;

  initial begin
    rst_n = 1'b0; halt = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
    jump_req = 1'b0; jump_addr = 16'h0000; ir_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_write_en}, 32'd0);
    chk("rst_pc_load", {16'd0, pc_load}, 32'd0);
    chk("rst_ir_data", {16'd0, ir_data}, 32'd0);
    chk("rst_ir_pc", {16'd0, ir_pc}, 32'd0);

    // Test 1: first fetch, memory answers in the 2nd mem_rd cycle.
    rst_n = 1'b1;
    ir_ready = 1'b1;
    inc0 = inc_count;
    tick();
    chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("t1_mem_addr", {16'd0, mem_addr}, 32'h0000);
    tick();
    chk("t1_mem_rd_wait", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ready = 1'b0;
    chk("t1_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("t1_ir_data", {16'd0, ir_data}, 32'h1234);
    chk("t1_ir_pc", {16'd0, ir_pc}, 32'h0000);
    chk("t1_pc_inc", {31'd0, pc_inc}, 32'd1);
    chk("t1_mem_rd_off", {31'd0, mem_rd}, 32'd0);
    tick();
    chk("t1_ir_valid_drop", {31'd0, ir_valid}, 32'd0);
    chk("t1_pc_inc_off", {31'd0, pc_inc}, 32'd0);
    chk("t1_next_rd", {31'd0, mem_rd}, 32'd1);
    chk("t1_next_addr", {16'd0, mem_addr}, 32'h0001);
    chk("t1_inc_pulses", inc_count - inc0, 32'd1);

    // Test 2: decoder stalls for 5 cycles after capture.
    ir_ready = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'h5678;
    tick();
    mem_ready = 1'b0;
    chk("t2_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("t2_ir_pc", {16'd0, ir_pc}, 32'h0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", {31'd0, ir_valid}, 32'd1);
      chk("t2_hold_data", {16'd0, ir_data}, 32'h5678);
      chk("t2_hold_pc", {16'd0, ir_pc}, 32'h0001);
      chk("t2_hold_rd", {31'd0, mem_rd}, 32'd0);
      chk("t2_hold_inc", {31'd0, pc_inc}, 32'd0);
    end
    chk("t2_inc_pulses", inc_count - inc0, 32'd2);
    ir_ready = 1'b1;
    tick();
    chk("t2_valid_drop", {31'd0, ir_valid}, 32'd0);
    chk("t2_next_rd", {31'd0, mem_rd}, 32'd1);
    chk("t2_next_addr", {16'd0, mem_addr}, 32'h0002);

    // Test 3: jump during the first HOLD cycle (the pc_inc cycle).
    ir_ready = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'h9ABC;
    tick();
    mem_ready = 1'b0;
    chk("t3_pc_inc", {31'd0, pc_inc}, 32'd1);
    jump_req = 1'b1; jump_addr = 16'h00A0;
    tick();
    jump_req = 1'b0;
    chk("t3_pc_we", {31'd0, pc_write_en}, 32'd1);
    chk("t3_pc_load", {16'd0, pc_load}, 32'h00A0);
    chk("t3_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("t3_pc_inc_off", {31'd0, pc_inc}, 32'd0);
    chk("t3_mem_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    chk("t3_pc_we_off", {31'd0, pc_write_en}, 32'd0);
    chk("t3_next_rd", {31'd0, mem_rd}, 32'd1);
    chk("t3_next_addr", {16'd0, mem_addr}, 32'h00A0);

    // Test 4: jump coincides with mem_ready; returned data is dropped.
    inc0 = inc_count;
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    jump_req = 1'b1; jump_addr = 16'h0100;
    ir_ready = 1'b0;
    tick();
    mem_ready = 1'b0; jump_req = 1'b0;
    chk("t4_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("t4_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("t4_pc_we", {31'd0, pc_write_en}, 32'd1);
    chk("t4_pc_load", {16'd0, pc_load}, 32'h0100);
    tick();
    chk("t4_next_rd", {31'd0, mem_rd}, 32'd1);
    chk("t4_next_addr", {16'd0, mem_addr}, 32'h0100);
    chk("t4_no_inc", inc_count - inc0, 32'd0);

    // Test 5: fetch from 0xFFFF wraps to 0x0000.
    jump_req = 1'b1; jump_addr = 16'hFFFF;
    tick();
    jump_req = 1'b0;
    tick();
    chk("t5_addr", {16'd0, mem_addr}, 32'hFFFF);
    chk("t5_rd", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 16'h4321; ir_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t5_ir_pc", {16'd0, ir_pc}, 32'hFFFF);
    chk("t5_ir_data", {16'd0, ir_data}, 32'h4321);
    chk("t5_pc_inc", {31'd0, pc_inc}, 32'd1);
    tick();
    chk("t5_wrap_rd", {31'd0, mem_rd}, 32'd1);
    chk("t5_wrap_addr", {16'd0, mem_addr}, 32'h0000);

    // Test 6: asynchronous reset mid-REQ, then halt keeps fetch idle.
    tick();
    chk("t6_in_req", {31'd0, mem_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rd", {31'd0, mem_rd}, 32'd0);
    chk("t6_async_valid", {31'd0, ir_valid}, 32'd0);
    chk("t6_async_inc", {31'd0, pc_inc}, 32'd0);
    halt = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick(); tick();
    rst_n = 1'b1;
    rd0 = rd_count;
    for (int i = 0; i < 10; i++) begin
      mem_ready = (i % 2 == 0);
      tick();
    end
    mem_ready = 1'b0;
    chk("t6_no_rd", rd_count - rd0, 32'd0);
    chk("t6_rd_low", {31'd0, mem_rd}, 32'd0);
    chk("t6_no_valid", {31'd0, ir_valid}, 32'd0);
    chk("t6_no_capture", {16'd0, ir_data}, 32'h0000);

    chk("pc_strobe_overlap", both_count, 32'd0);
    chk("beef_never_valid", beef_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
